// File: rtl/mem_responder.sv
// Single-outstanding data-memory responder: latches one request, waits a fixed
// latency, then holds the response until the CPU accepts it.
module mem_responder #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned LATENCY     = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam int unsigned CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY >= 2) ? CNT_W'(LATENCY - 2) : '0;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             wr_q;
   logic [31:0]      addr_q, wdata_q;
   logic             ready_q, ready_d;
   logic             valid_q, valid_d;
   logic [31:0]      rdata_q, rdata_d;
   logic             err_q, err_d;

   logic [31:0] mem [DEPTH_WORDS];

   logic             capture;
   logic             enter_resp;
   logic             cur_write;
   logic [31:0]      cur_addr;
   logic [31:0]      cur_wdata;
   logic             cur_err;
   logic [IDX_W-1:0] cur_idx;

   // With LATENCY == 1 the access happens on the accepting edge, so use live inputs then
   always_comb begin
      cur_write = capture ? req_write : wr_q;
      cur_addr  = capture ? req_addr  : addr_q;
      cur_wdata = capture ? req_wdata : wdata_q;
      cur_idx   = cur_addr[IDX_W+1:2];
      cur_err   = (cur_addr[1:0] != 2'b00) || (cur_addr[31:2] >= 30'(DEPTH_WORDS));
   end

   // Next-state and response-data logic
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      capture    = 1'b0;
      enter_resp = 1'b0;
      rdata_d    = rdata_q;
      err_d      = err_q;
      case (state_q)
         IDLE: begin
            if (req_valid && ready_q) begin
               capture = 1'b1;
               if (LATENCY == 32'd1) begin
                  state_d    = RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_d = WAIT;
                  cnt_d   = CNT_INIT;
               end
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               state_d    = RESP;
               enter_resp = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         RESP: begin
            if (resp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (enter_resp) begin
         err_d   = cur_err;
         rdata_d = (!cur_write && !cur_err) ? mem[cur_idx] : 32'd0;
      end
      ready_d = (state_d == IDLE);
      valid_d = (state_d == RESP);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         wr_q    <= 1'b0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         ready_q <= 1'b0;
         valid_q <= 1'b0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ready_q <= ready_d;
         valid_q <= valid_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         if (capture) begin
            wr_q    <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
         end
      end
   end

   // Storage is deliberately not reset; a store commits only on the edge entering RESP
   always_ff @(posedge clk) begin
      if (!reset && enter_resp && cur_write && !cur_err) begin
         mem[cur_idx] <= cur_wdata;
      end
   end

   assign req_ready  = ready_q;
   assign resp_valid = valid_q;
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a LATENCY=4 instance for the main flow and
// a LATENCY=1 instance for back-to-back timing.
module tb_mem_responder;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned LAT4  = 4;

   logic        clk = 1'b0;
   logic        reset;
   int          checks = 0;
   int          errors = 0;

   logic        req_valid4, req_ready4, req_write4, resp_valid4, resp_ready4, resp_err4;
   logic [31:0] req_addr4, req_wdata4, resp_rdata4;
   logic        req_valid1, req_ready1, req_write1, resp_valid1, resp_ready1, resp_err1;
   logic [31:0] req_addr1, req_wdata1, resp_rdata1;

   always #5 clk = ~clk;

   mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT4)) u_dut4 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid4), .req_ready(req_ready4), .req_write(req_write4),
      .req_addr(req_addr4), .req_wdata(req_wdata4),
      .resp_valid(resp_valid4), .resp_ready(resp_ready4),
      .resp_rdata(resp_rdata4), .resp_err(resp_err4)
   );

   mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) u_dut1 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid1), .req_ready(req_ready1), .req_write(req_write1),
      .req_addr(req_addr1), .req_wdata(req_wdata1),
      .resp_valid(resp_valid1), .resp_ready(resp_ready1),
      .resp_rdata(resp_rdata1), .resp_err(resp_err1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one request on the LATENCY=4 instance and step to the first RESP cycle
   task automatic start_req(input string tag, input logic w, input logic [31:0] a,
                            input logic [31:0] d);
      check({tag, ":req_ready"}, 32'(req_ready4), 32'd1);
      req_valid4 = 1'b1; req_write4 = w; req_addr4 = a; req_wdata4 = d;
      tick();
      req_valid4 = 1'b0; req_write4 = ~w; req_addr4 = ~a; req_wdata4 = ~d;
      check({tag, ":busy"}, 32'(req_ready4), 32'd0);
      for (int k = 1; k < int'(LAT4); k++) begin
         check({tag, ":early_valid"}, 32'(resp_valid4), 32'd0);
         tick();
      end
      check({tag, ":resp_valid"}, 32'(resp_valid4), 32'd1);
   endtask

   task automatic finish_resp(input string tag, input logic [31:0] exp_r, input logic exp_e);
      check({tag, ":rdata"}, resp_rdata4, exp_r);
      check({tag, ":err"}, 32'(resp_err4), 32'(exp_e));
      resp_ready4 = 1'b1;
      tick();
      resp_ready4 = 1'b0;
      check({tag, ":valid_drop"}, 32'(resp_valid4), 32'd0);
      check({tag, ":ready_back"}, 32'(req_ready4), 32'd1);
   endtask

   initial begin
      reset = 1'b1;
      req_valid4 = 1'b1; req_write4 = 1'b1; req_addr4 = 32'h10; req_wdata4 = 32'h1;
      resp_ready4 = 1'b0;
      req_valid1 = 1'b1; req_write1 = 1'b0; req_addr1 = 32'h0; req_wdata1 = 32'h0;
      resp_ready1 = 1'b0;

      // Reset state, with req_valid held high throughout
      tick(); tick(); tick();
      check("rst:req_ready", 32'(req_ready4), 32'd0);
      check("rst:resp_valid", 32'(resp_valid4), 32'd0);
      check("rst:rdata", resp_rdata4, 32'd0);
      check("rst:err", 32'(resp_err4), 32'd0);
      check("rst:req_ready1", 32'(req_ready1), 32'd0);
      reset = 1'b0;
      req_valid4 = 1'b0;
      req_valid1 = 1'b0;
      tick();
      check("post_rst:req_ready", 32'(req_ready4), 32'd1);
      check("post_rst:resp_valid", 32'(resp_valid4), 32'd0);

      // Store then load
      start_req("st10", 1'b1, 32'h10, 32'hDEADBEEF);
      finish_resp("st10", 32'd0, 1'b0);
      start_req("ld10", 1'b0, 32'h10, 32'h0);
      finish_resp("ld10", 32'hDEADBEEF, 1'b0);

      // Misaligned store must not touch memory; out-of-range load errors
      start_req("st12", 1'b1, 32'h12, 32'h12345678);
      finish_resp("st12", 32'd0, 1'b1);
      start_req("ld10b", 1'b0, 32'h10, 32'h0);
      finish_resp("ld10b", 32'hDEADBEEF, 1'b0);
      start_req("ld_oor", 1'b0, 32'(4 * DEPTH), 32'h0);
      finish_resp("ld_oor", 32'd0, 1'b1);

      // Backpressure with stray store requests pulsed during RESP
      start_req("bp", 1'b0, 32'h10, 32'h0);
      for (int k = 0; k < 5; k++) begin
         req_valid4 = k[0]; req_write4 = 1'b1; req_addr4 = 32'h10; req_wdata4 = 32'h0;
         check("bp:req_ready", 32'(req_ready4), 32'd0);
         tick();
         check("bp:valid", 32'(resp_valid4), 32'd1);
         check("bp:rdata", resp_rdata4, 32'hDEADBEEF);
         check("bp:err", 32'(resp_err4), 32'd0);
      end
      req_valid4 = 1'b0;
      finish_resp("bp", 32'hDEADBEEF, 1'b0);
      start_req("bp_ld", 1'b0, 32'h10, 32'h0);
      finish_resp("bp_ld", 32'hDEADBEEF, 1'b0);

      // Inputs scrambled after accept: access must use latched values
      start_req("st24", 1'b1, 32'h24, 32'h0BADF00D);
      finish_resp("st24", 32'd0, 1'b0);
      start_req("ld24", 1'b0, 32'h24, 32'h0);
      finish_resp("ld24", 32'h0BADF00D, 1'b0);

      // Reset during WAIT aborts a pending store
      start_req("st20", 1'b1, 32'h20, 32'h11);
      finish_resp("st20", 32'd0, 1'b0);
      req_valid4 = 1'b1; req_write4 = 1'b1; req_addr4 = 32'h20; req_wdata4 = 32'h55;
      tick();
      req_valid4 = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rstw:req_ready", 32'(req_ready4), 32'd0);
      for (int k = 0; k < 6; k++) begin
         check("rstw:no_valid", 32'(resp_valid4), 32'd0);
         tick();
      end
      start_req("ld20", 1'b0, 32'h20, 32'h0);
      finish_resp("ld20", 32'h11, 1'b0);

      // LATENCY=1: store accepted at edge N, load accepted back-to-back at N+2
      check("l1:req_ready", 32'(req_ready1), 32'd1);
      req_valid1 = 1'b1; req_write1 = 1'b1; req_addr1 = 32'h4; req_wdata1 = 32'hCAFEF00D;
      resp_ready1 = 1'b1;
      tick();
      req_write1 = 1'b0; req_wdata1 = 32'h0;
      check("l1:valid_n1", 32'(resp_valid1), 32'd1);
      check("l1:ready_n1", 32'(req_ready1), 32'd0);
      check("l1:err_n1", 32'(resp_err1), 32'd0);
      tick();
      check("l1:valid_n2", 32'(resp_valid1), 32'd0);
      check("l1:ready_n2", 32'(req_ready1), 32'd1);
      tick();
      req_valid1 = 1'b0;
      check("l1:valid_n3", 32'(resp_valid1), 32'd1);
      check("l1:rdata_n3", resp_rdata1, 32'hCAFEF00D);
      check("l1:err_n3", 32'(resp_err1), 32'd0);
      tick();
      resp_ready1 = 1'b0;
      check("l1:valid_n4", 32'(resp_valid1), 32'd0);
      check("l1:ready_n4", 32'(req_ready1), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words stored (power of 2, >= 2).
REQ-002 SHALL have parameter LATENCY, default 4, cycles from request accept to response valid (>= 1).
REQ-003 SHALL have port clk  input  1  clock; all state updates on posedge clk.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  CPU presents a data-memory request.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request this cycle.
REQ-007 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data.
REQ-010 SHALL have port resp_valid  output  1  response available.
REQ-011 SHALL have port resp_ready  input  1  CPU accepts the response.
REQ-012 SHALL have port resp_rdata  output  32  load data; 0 for stores and errors.
REQ-013 SHALL have port resp_err  output  1  request was misaligned or out of range.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-015 SHALL drive req_ready = 1 only in IDLE.
REQ-016 SHALL accept a request on any edge with req_valid && req_ready, latching req_write, req_addr and req_wdata; later changes on req_* SHALL be ignored until the next accept.
REQ-017 On accept, SHALL go to RESP if LATENCY == 1; otherwise SHALL go to WAIT with the down-counter loaded with LATENCY-2.
REQ-018 In WAIT, SHALL go to RESP when the counter is 0; otherwise SHALL decrement it.
REQ-019 resp_valid SHALL first be high exactly LATENCY cycles after the accepting edge, and SHALL be high in RESP only.
REQ-020 Word index SHALL be latched req_addr[31:2]; the request SHALL be in range iff the word index < DEPTH_WORDS.
REQ-021 An error SHALL be flagged when latched addr[1:0] != 0 or the request is out of range.
REQ-022 A valid store SHALL write mem[index] = wdata on the edge entering RESP; an erroring store SHALL NOT modify memory.
REQ-023 A valid load SHALL capture mem[index] into resp_rdata on the edge entering RESP.
REQ-024 resp_rdata SHALL be 0 for stores and errors, and resp_err SHALL be 1 only on errors.
REQ-025 resp_valid, resp_rdata and resp_err SHALL be held stable in RESP until resp_ready is sampled high.
REQ-026 On that edge, SHALL return to IDLE, with resp_valid low next cycle.
REQ-027 At most one transaction SHALL be outstanding; the next accept can occur no earlier than the cycle after the response handshake.
REQ-028 resp_ready SHALL be ignored outside RESP.
REQ-029 req_valid SHALL be ignored outside IDLE.

Reset
REQ-030 While reset is high, SHALL force IDLE, counter 0, req_ready 0, resp_valid 0, resp_rdata 0, resp_err 0.
REQ-031 req_ready SHALL be 1 on the first cycle after reset deasserts.
REQ-032 Reset during WAIT SHALL abort the transaction; the pending store SHALL NOT be written.
REQ-033 Reset during RESP SHALL drop the response; a store already committed SHALL remain.
REQ-034 Memory array contents SHALL NOT be cleared by reset.
REQ-035 A req_valid sampled in the same cycle as reset SHALL NOT be accepted.

Verification
REQ-036 Store then load, LATENCY=4: store addr 0x10, data 0xDEADBEEF, accepted edge 0 -> resp_valid high from cycle 4, resp_err 0; then load 0x10 -> resp_rdata 0xDEADBEEF, resp_err 0.
REQ-037 LATENCY=1: load accepted edge N -> resp_valid high cycle N+1; with resp_ready held 1, req_ready high cycle N+2 and back-to-back request accepted then.
REQ-038 Backpressure: resp_ready held 0 for 5 cycles in RESP -> resp_valid/rdata/err stable; req_valid pulses meanwhile not accepted; handshake on cycle 6 -> IDLE next.
REQ-039 Errors: store to 0x12 -> resp_err 1, later load of word 0x10 unchanged; load at byte 4*DEPTH_WORDS -> resp_err 1, resp_rdata 0.
REQ-040 Reset mid-WAIT: store 0x55 to 0x20 (old 0x11), reset asserted 1 cycle in WAIT -> resp_valid never rises, load of 0x20 returns 0x11.
REQ-041 Input stability: change req_addr/req_wdata during WAIT -> access uses the values latched at accept.
